// File: rtl/denominator_pkg.sv
// Shared constants, the 2^(2^-k) ROM and the FSM state type for the sigmoid denominator.
package denominator_pkg;

    localparam int unsigned FRAC_BITS = 16;

    localparam logic [31:0] ONE_Q16 = 32'h0001_0000;
    localparam logic [31:0] ONE_Q30 = 32'h4000_0000;
    localparam logic [31:0] LOG2E   = 32'h0001_7154;

    // Beyond +/-64.0 the result is saturated outright, which keeps y inside 16 integer bits.
    localparam logic signed [31:0] X_LIMIT = 32'sh0040_0000;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        POW,
        SHIFT,
        ADD,
        DONE
    } state_e;

    // POW2[k] = 2^(2^-k) in Q2.30, k = 1..16
    function automatic logic [31:0] pow2_rom(input logic [4:0] k);
        case (k)
            5'd1:    return 32'h5A82_799A;
            5'd2:    return 32'h4C1B_F829;
            5'd3:    return 32'h45CA_E0F2;
            5'd4:    return 32'h42D5_61B4;
            5'd5:    return 32'h4166_C34C;
            5'd6:    return 32'h40B2_68FA;
            5'd7:    return 32'h4058_F6A8;
            5'd8:    return 32'h402C_6BE9;
            5'd9:    return 32'h4016_321B;
            5'd10:   return 32'h400B_1817;
            5'd11:   return 32'h4005_8BCE;
            5'd12:   return 32'h4002_C5D8;
            5'd13:   return 32'h4001_62E8;
            5'd14:   return 32'h4000_B173;
            5'd15:   return 32'h4000_58B9;
            5'd16:   return 32'h4000_2C5D;
            default: return ONE_Q30;
        endcase
    endfunction

endpackage

// File: rtl/denominator_exp2_frac_iter.sv
// Iterative 2^f for f in [0,1): one fractional bit of f per cycle, MSB first, result in Q2.30.
module exp2_frac_iter
    import denominator_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic [15:0] f_i,
    output logic        busy_o,
    output logic [31:0] result_o
);

    logic [31:0] acc_q, acc_d;
    logic [15:0] f_q, f_d;
    logic [4:0]  k_q, k_d;

    // NOTE: every signal written here gets its default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        acc_d = acc_q;
        f_d   = f_q;
        k_d   = k_q;
        if (load_i) begin
            acc_d = ONE_Q30;
            f_d   = f_i;
            k_d   = 5'd1;
        end else if (k_q != 5'd0) begin
            if (f_q[15]) begin
                acc_d = 32'((64'(acc_q) * 64'(pow2_rom(k_q))) >> 30);
            end
            f_d = f_q << 1;
            k_d = (k_q == 5'(FRAC_BITS)) ? 5'd0 : k_q + 5'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments and a synchronous reset sampled on the clock edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q <= '0;
            f_q   <= '0;
            k_q   <= '0;
        end else begin
            acc_q <= acc_d;
            f_q   <= f_d;
            k_q   <= k_d;
        end
    end

    // Drops during the final iteration so a waiting FSM steps on exactly as the last bit lands.
    assign busy_o   = (k_q != 5'd0) && (k_q != 5'(FRAC_BITS));
    assign result_o = acc_q;

endmodule

// File: rtl/denominator.sv
// Sigmoid denominator D = 1 + e^(-X), X signed Q16.16, D unsigned Q16.16, fixed 20-cycle latency.
module denominator
    import denominator_pkg::*;
(
    input  logic        CLOCK,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] X,
    output logic        startout,
    output logic [31:0] denom
);

    state_e state_q, state_d;

    logic [31:0]       x_q, x_d;
    logic signed [4:0] n_q, n_d;
    logic              sat_hi_q, sat_hi_d;
    logic              sat_lo_q, sat_lo_d;
    logic [31:0]       e_q, e_d;
    logic [31:0]       sum_q, sum_d;
    logic [31:0]       denom_q, denom_d;
    logic              startout_q, startout_d;

    logic signed [47:0] prod;
    logic [31:0]        y;
    logic signed [15:0] n_full;
    logic               x_pos_big, x_neg_big;
    logic [4:0]         n_neg;
    logic [5:0]         rsh;
    logic [32:0]        add_full;

    logic        exp_load, exp_busy;
    logic [31:0] exp_result;

    exp2_frac_iter u_exp2 (
        .clk_i    (CLOCK),
        .reset_i  (reset),
        .load_i   (exp_load),
        .f_i      (y[15:0]),
        .busy_o   (exp_busy),
        .result_o (exp_result)
    );

    // y = round_half_up(-X * log2(e)) in Q16.16; the product carries 32 fraction bits.
    assign prod      = $signed({{16{x_q[31]}}, x_q}) * $signed({16'd0, LOG2E});
    assign y         = 32'((48'sd32768 - prod) >>> FRAC_BITS);
    assign n_full    = y[31:16];
    assign x_pos_big = $signed(x_q) > X_LIMIT;
    assign x_neg_big = $signed(x_q) < -X_LIMIT;

    assign n_neg    = 5'(-n_q);
    assign rsh      = 6'd14 + {1'b0, n_neg};
    assign add_full = {1'b0, e_q} + {1'b0, ONE_Q16};

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        n_d        = n_q;
        sat_hi_d   = sat_hi_q;
        sat_lo_d   = sat_lo_q;
        e_d        = e_q;
        sum_d      = sum_q;
        denom_d    = denom_q;
        startout_d = 1'b0;
        exp_load   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = X;
                    state_d = MUL;
                end
            end
            MUL: begin
                exp_load = 1'b1;
                n_d      = y[20:16];
                sat_hi_d = x_neg_big || (!x_pos_big && (n_full >= 16'sd16));
                sat_lo_d = x_pos_big || (!x_neg_big && (n_full <= -16'sd17));
                state_d  = POW;
            end
            POW: begin
                if (!exp_busy) state_d = SHIFT;
            end
            SHIFT: begin
                // Q2.30 -> Q16.16 is a right shift by 14, folded into the 2^n scaling.
                if (sat_lo_q)    e_d = '0;
                else if (n_q[4]) e_d = exp_result >> rsh;
                else             e_d = 32'(({15'd0, exp_result} << n_q[3:0]) >> 14);
                state_d = ADD;
            end
            ADD: begin
                sum_d   = (sat_hi_q || add_full[32]) ? 32'hFFFF_FFFF : add_full[31:0];
                state_d = DONE;
            end
            DONE: begin
                denom_d    = sum_q;
                startout_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            n_q        <= '0;
            sat_hi_q   <= 1'b0;
            sat_lo_q   <= 1'b0;
            e_q        <= '0;
            sum_q      <= '0;
            denom_q    <= '0;
            startout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            n_q        <= n_d;
            sat_hi_q   <= sat_hi_d;
            sat_lo_q   <= sat_lo_d;
            e_q        <= e_d;
            sum_q      <= sum_d;
            denom_q    <= denom_d;
            startout_q <= startout_d;
        end
    end

    assign startout = startout_q;
    assign denom    = denom_q;

endmodule

// File: tb/tb_denominator.sv
// Directed bench for denominator: latency, results within tolerance, saturation, busy-start and abort.
module tb_denominator;

    logic        CLOCK;
    logic        reset;
    logic        start;
    logic [31:0] X;
    logic        startout;
    logic [31:0] denom;

    int checks   = 0;
    int failures = 0;

    denominator dut (
        .CLOCK    (CLOCK),
        .reset    (reset),
        .start    (start),
        .X        (X),
        .startout (startout),
        .denom    (denom)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp, input logic [31:0] tol);
        logic [31:0] diff;
        checks++;
        diff = (got > exp) ? got - exp : exp - got;
        if ($isunknown(got) || diff > tol) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (tol %0d)", tag, got, exp, tol);
        end
    endtask

    // Start one operation, scramble X while busy, and wait (bounded) for startout.
    task automatic run_op(input logic [31:0] x, output int lat, output logic [31:0] res);
        bit found;
        X     = x;
        start = 1'b1;
        @(posedge CLOCK);
        #1;
        start = 1'b0;
        X     = $urandom;
        lat   = 0;
        found = 1'b0;
        res   = 32'h0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge CLOCK);
            #1;
            if (!found && startout) begin
                found = 1'b1;
                lat   = c;
                res   = denom;
            end
            if (found) c = 41;
        end
    endtask

    task automatic op_check(input string tag, input logic [31:0] x,
                            input logic [31:0] exp, input logic [31:0] tol);
        int          lat;
        logic [31:0] res;
        run_op(x, lat, res);
        check({tag, "_latency"}, 32'(lat), 32'd20, 32'd0);
        check({tag, "_denom"}, res, exp, tol);
        @(posedge CLOCK);
        #1;
        check({tag, "_pulse_width"}, {31'd0, startout}, 32'd0, 32'd0);
    endtask

    initial begin
        int          pulses;
        int          first;
        logic [31:0] res;

        reset = 1'b1;
        start = 1'b0;
        X     = 32'h0;
        repeat (3) @(posedge CLOCK);
        #1;
        check("reset_denom", denom, 32'h0, 32'd0);
        check("reset_startout", {31'd0, startout}, 32'd0, 32'd0);
        reset = 1'b0;
        @(posedge CLOCK);
        #1;

        op_check("x_zero",   32'h0000_0000, 32'h0002_0000, 32'd32);
        op_check("x_pos10",  32'h000A_0000, 32'h0001_0003, 32'd2);
        op_check("x_neg10",  32'hFFF6_0000, 32'h560B_773E, 32'h0005_60B7);
        op_check("x_neg5",   32'hFFFB_0000, 32'h0095_69C5, 32'h0000_0956);
        op_check("x_neg12",  32'hFFF4_0000, 32'hFFFF_FFFF, 32'd0);
        repeat (3) @(posedge CLOCK);
        #1;
        check("hold_denom", denom, 32'hFFFF_FFFF, 32'd0);
        op_check("x_pos20",  32'h0014_0000, 32'h0001_0000, 32'd0);
        op_check("x_most_neg", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Extra starts at cycle 5 (busy) and on the DONE edge must both be ignored.
        X      = 32'h0000_0000;
        start  = 1'b1;
        @(posedge CLOCK);
        #1;
        start  = 1'b0;
        pulses = 0;
        first  = 0;
        res    = 32'h0;
        for (int c = 1; c <= 40; c++) begin
            start = (c == 5) || (c == 20);
            if (c == 5) X = 32'hFFF6_0000;
            @(posedge CLOCK);
            #1;
            start = 1'b0;
            if (startout) begin
                pulses++;
                if (first == 0) begin
                    first = c;
                    res   = denom;
                end
            end
        end
        check("busy_start_latency", 32'(first), 32'd20, 32'd0);
        check("busy_start_denom", res, 32'h0002_0000, 32'd32);
        check("busy_start_pulses", 32'(pulses), 32'd1, 32'd0);

        // Reset in the middle of an operation aborts it.
        X      = 32'hFFFB_0000;
        start  = 1'b1;
        @(posedge CLOCK);
        #1;
        start  = 1'b0;
        pulses = 0;
        for (int c = 1; c <= 40; c++) begin
            reset = (c == 10);
            @(posedge CLOCK);
            #1;
            if (startout) pulses++;
        end
        reset = 1'b0;
        check("abort_pulses", 32'(pulses), 32'd0, 32'd0);
        check("abort_denom", denom, 32'h0, 32'd0);
        op_check("after_abort", 32'h0014_0000, 32'h0001_0000, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
